tdc_bank_regfile: RTL and testbench

- Parametrised AXI4-Lite register file for the TDC bank IP, successor to the fixed four-register slave.
- Provides NUM_RW software-writable registers with byte strobes, and NUM_RO read-only registers that snapshot hardware sample words on a capture strobe.
- Provides a capture counter, a self-clearing start pulse, and SLVERR on out-of-range addresses.
- Sits between the PS AXI interconnect and the TDC sensor array/control logic.

---
 rtl/tdc_bank_regfile.sv | 186 ++++++++++++++++++
 tb/tb_tdc_bank_regfile.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_bank_regfile.sv
// AXI4-Lite register file for the TDC bank: NUM_RW strobed control registers,
// NUM_RO capture-strobed snapshot registers, a capture counter and a start pulse.
module tdc_bank_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs_o,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ro_data_i,
    input  logic                         capture_i,
    output logic                         start_o
);
    localparam int IDX_W   = ADDR_WIDTH - 2;
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int CAP_IDX = NUM_RW + NUM_RO;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [NUM_RW-1:0][DATA_WIDTH-1:0] rw_q, rw_d;
    logic [NUM_RO-1:0][DATA_WIDTH-1:0] ro_q;
    logic [DATA_WIDTH-1:0]             capcnt_q;
    logic [DATA_WIDTH-1:0]             rdata_q, rd_word;
    logic [1:0]                        bresp_q, rresp_q;
    logic                              awready_q, arready_q, start_q, rd_err;
    logic                              wr_en, rd_en, cap_fire;
    logic [IDX_W-1:0]                  wr_idx, rd_idx;
    logic                              unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx   = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign rd_idx   = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign wr_en    = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_en    = arready_q && S_AXI_ARVALID;
    // Uses the CAP_EN value before any same-cycle CTRL write.
    assign cap_fire = capture_i && rw_q[0][1];

    // Write channel: state register, next state, outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state_q <= W_IDLE;
        else        w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (wr_en) w_state_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_BVALID  = (w_state_q == W_RESP);
        S_AXI_AWREADY = awready_q;
        S_AXI_WREADY  = awready_q;
        S_AXI_BRESP   = bresp_q;
    end

    // Read channel: state register, next state, outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (rd_en) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_RVALID  = (r_state_q == R_DATA);
        S_AXI_ARREADY = arready_q;
        S_AXI_RDATA   = rdata_q;
        S_AXI_RRESP   = rresp_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            start_q   <= 1'b0;
        end else begin
            awready_q <= (w_state_q == W_IDLE) && !awready_q && S_AXI_AWVALID && S_AXI_WVALID;
            arready_q <= (r_state_q == R_IDLE) && !arready_q && S_AXI_ARVALID;
            start_q   <= wr_en && (wr_idx == '0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
            if (wr_en)
                bresp_q <= (wr_idx > IDX_W'(CAP_IDX)) ? 2'b10 : 2'b00;
            if (rd_en) begin
                rdata_q <= rd_word;
                rresp_q <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    // Byte-strobed RW update; CTRL bit0 is a pulse, never stored.
    always_comb begin
        rw_d = rw_q;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_en && wr_idx == IDX_W'(i)) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (S_AXI_WSTRB[b]) rw_d[i][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                end
            end
        end
        rw_d[0][0] = 1'b0;
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = rw_q[i];
                rd_err  = 1'b0;
            end
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (rd_idx == IDX_W'(NUM_RW + i)) begin
                rd_word = ro_q[i];
                rd_err  = 1'b0;
            end
        end
        if (rd_idx == IDX_W'(CAP_IDX)) begin
            rd_word = capcnt_q;
            rd_err  = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rw_q     <= '0;
            ro_q     <= '0;
            capcnt_q <= '0;
        end else begin
            rw_q <= rw_d;
            if (cap_fire) begin
                for (int i = 0; i < NUM_RO; i++)
                    ro_q[i] <= ro_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                capcnt_q <= capcnt_q + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw_out
            assign rw_regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = rw_q[gi];
        end
    endgenerate

    assign start_o = start_q;

endmodule

// File: tb/tb_tdc_bank_regfile.sv
// Directed scoreboard bench for tdc_bank_regfile: expected responses are queued
// from a small register model when a transaction is issued and checked on response.
module tb_tdc_bank_regfile;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NRW = 4;
    localparam int NRO = 4;
    localparam int CAP = NRW + NRO;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [AW-1:0]     S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]        S_AXI_AWPROT, S_AXI_ARPROT;
    logic              S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [DW-1:0]     S_AXI_WDATA, S_AXI_RDATA;
    logic [DW/8-1:0]   S_AXI_WSTRB;
    logic [1:0]        S_AXI_BRESP, S_AXI_RRESP;
    logic              S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic              S_AXI_RVALID, S_AXI_RREADY;
    logic [NRW*DW-1:0] rw_regs_o;
    logic [NRO*DW-1:0] ro_data_i;
    logic              capture_i, start_o;

    tdc_bank_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .rw_regs_o(rw_regs_o), .ro_data_i(ro_data_i),
        .capture_i(capture_i), .start_o(start_o)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        rq[$];
    logic [1:0]  wq[$];
    logic [31:0] mdl_rw [NRW];
    logic [31:0] mdl_ro [NRO];
    logic [31:0] mdl_cnt;
    int          n_cmp = 0;
    int          n_err = 0;
    int          start_cnt = 0;

    always @(negedge ACLK) if (start_o === 1'b1) start_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, required finish before 300us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed timeout expected handshake within 20 cycles", tag);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NRW; i++) mdl_rw[i] = '0;
        for (int i = 0; i < NRO; i++) mdl_ro[i] = '0;
        mdl_cnt = '0;
    endtask

    task automatic model_capture();
        if (mdl_rw[0][1]) begin
            for (int i = 0; i < NRO; i++) mdl_ro[i] = ro_data_i[i*DW +: DW];
            mdl_cnt = mdl_cnt + 1;
        end
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[7:2]);
        wq.push_back((idx > CAP) ? 2'b10 : 2'b00);
        if (idx < NRW) begin
            for (int b = 0; b < 4; b++) if (s[b]) mdl_rw[idx][8*b +: 8] = d[8*b +: 8];
        end
        mdl_rw[0][0] = 1'b0;
    endtask

    function automatic exp_t model_read(input logic [7:0] a);
        exp_t e;
        int idx;
        idx = int'(a[7:2]);
        e.resp = (idx > CAP) ? 2'b10 : 2'b00;
        if (idx < NRW)      e.data = mdl_rw[idx];
        else if (idx < CAP) e.data = mdl_ro[idx-NRW];
        else if (idx == CAP) e.data = mdl_cnt;
        else                e.data = '0;
        return e;
    endfunction

    // Optionally pulses capture_i in the same cycle as the address handshake.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit cap, input bit exp_start);
        bit ok;
        if (cap) model_capture();
        model_write(a, d, s);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout($sformatf("awready@%0h", a));
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            void'(wq.pop_front());
            return;
        end
        if (cap) capture_i = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; capture_i = 1'b0;
        check($sformatf("start_o@%0h", a), 64'(start_o), 64'(exp_start));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (S_AXI_BVALID) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        if (!ok) timeout($sformatf("bvalid@%0h", a));
        else     check($sformatf("bresp@%0h", a), 64'(S_AXI_BRESP), 64'(wq.pop_front()));
        @(negedge ACLK);
    endtask

    task automatic axi_read(input logic [7:0] a, input bit cap);
        bit ok;
        exp_t e;
        rq.push_back(model_read(a));
        if (cap) model_capture();
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            timeout($sformatf("arready@%0h", a));
            S_AXI_ARVALID = 1'b0;
            void'(rq.pop_front());
            return;
        end
        if (cap) capture_i = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0; capture_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (S_AXI_RVALID) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        e = rq.pop_front();
        if (!ok) timeout($sformatf("rvalid@%0h", a));
        else begin
            check($sformatf("rdata@%0h", a), 64'(S_AXI_RDATA), 64'(e.data));
            check($sformatf("rresp@%0h", a), 64'(S_AXI_RRESP), 64'(e.resp));
        end
        @(negedge ACLK);
    endtask

    task automatic pulse_capture();
        model_capture();
        capture_i = 1'b1;
        @(negedge ACLK);
        capture_i = 1'b0;
    endtask

    initial begin
        bit ok;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        ro_data_i = '0; capture_i = 1'b0;
        model_reset();
        repeat (3) @(negedge ACLK);
        check("reset_hs", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                               S_AXI_BVALID, S_AXI_RVALID, start_o}), 64'(0));
        check("reset_resp", 64'({S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP}), 64'(0));
        check("reset_rw_regs", 64'(rw_regs_o[63:0]) | 64'(rw_regs_o[127:64]), 64'(0));
        ARESET = 1'b0;
        @(negedge ACLK);

        // Every mapped index reads zero; the first unmapped one errors.
        for (int i = 0; i <= CAP + 1; i++) axi_read(8'(4*i), 1'b0);

        // START self-clears and pulses exactly once.
        for (int i = 0; i < NRW; i++) axi_write(8'(4*i), 32'(i+1), 4'hF, 1'b0, i == 0);
        check("start_count", 64'(start_cnt), 64'(1));
        for (int i = 0; i < NRW; i++) axi_read(8'(4*i), 1'b0);
        check("rw_regs_o", 64'(rw_regs_o[127:64]), {mdl_rw[3], mdl_rw[2]});

        // Byte strobes, plus writes that must change nothing.
        axi_write(8'h04, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
        axi_write(8'h04, 32'h11223344, 4'b0101, 1'b0, 1'b0);
        axi_read(8'h04, 1'b0);
        axi_write(8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        axi_write(8'h20, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        axi_write(8'h28, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        axi_read(8'h10, 1'b0);
        axi_read(8'h20, 1'b0);

        // Capture with CAP_EN set, then the same-cycle boundary cases.
        axi_write(8'h00, 32'h2, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < NRO; k++) ro_data_i[k*DW +: DW] = 32'hC0DE0000 + 32'(k);
        repeat (3) pulse_capture();
        for (int i = NRW; i <= CAP; i++) axi_read(8'(4*i), 1'b0);
        for (int k = 0; k < NRO; k++) ro_data_i[k*DW +: DW] = 32'hBEEF0000 + 32'(k);
        axi_read(8'h10, 1'b1);
        axi_read(8'h20, 1'b0);
        for (int k = 0; k < NRO; k++) ro_data_i[k*DW +: DW] = 32'hFACE0000 + 32'(k);
        axi_write(8'h00, 32'h0, 4'hF, 1'b1, 1'b0);
        for (int k = 0; k < NRO; k++) ro_data_i[k*DW +: DW] = 32'h0BAD0000 + 32'(k);
        pulse_capture();
        for (int i = NRW; i <= CAP; i++) axi_read(8'(4*i), 1'b0);

        // B-channel backpressure blocks a second write.
        model_write(8'h08, 32'h55, 4'hF);
        S_AXI_AWADDR = 8'h08; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("bp_first_aw");
        @(negedge ACLK);
        S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h66;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold[%0d]", i),
                  64'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 64'(3'b100));
            @(negedge ACLK);
        end
        check("bp_bresp1", 64'(S_AXI_BRESP), 64'(wq.pop_front()));
        S_AXI_BREADY = 1'b1;
        model_write(8'h0C, 32'h66, 4'hF);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("bp_second_aw");
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bp_bvalid2", 64'(S_AXI_BVALID), 64'(1));
        check("bp_bresp2", 64'(S_AXI_BRESP), 64'(wq.pop_front()));
        @(negedge ACLK);
        axi_read(8'h08, 1'b0);
        axi_read(8'h0C, 1'b0);

        // Asynchronous reset while a read response is pending.
        S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("rst_arready");
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rst_rvalid_before", 64'(S_AXI_RVALID), 64'(1));
        #2 ARESET = 1'b1;
        #1 check("rst_rvalid_async", 64'(S_AXI_RVALID), 64'(0));
        model_reset();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check($sformatf("post_rst_idle[%0d]", i), 64'({S_AXI_RVALID, S_AXI_BVALID}), 64'(0));
        end
        axi_read(8'h04, 1'b0);
        axi_read(8'h20, 1'b0);
        check("start_count_final", 64'(start_cnt), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
